// File: rtl/mma_pkg.sv
// Shared widths and state encoding for the MMA result serializer.
package mma_pkg;

    localparam int ACC_W   = 32;
    localparam int SHIFT_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage : mma_pkg

// File: rtl/mma_result_serializer_if.sv
// Matrix-in / row-out handshake bundle between the MAC stage, the serializer and writeback.
interface mma_result_serializer_if
    import mma_pkg::*;
#(
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int OUT_W = 8
);
    localparam int RIDX_W = (M > 1) ? $clog2(M) : 1;

    logic [M-1:0][N-1:0][ACC_W-1:0] D;
    logic [SHIFT_W-1:0]             shift;
    logic                           valid_in;
    logic                           ready_in;
    logic [N-1:0][OUT_W-1:0]        row_out;
    logic [RIDX_W-1:0]              row_idx;
    logic                           last_out;
    logic                           valid_out;
    logic                           ready_out;

    // Serializer side.
    modport slave (
        input  D, shift, valid_in, ready_out,
        output ready_in, row_out, row_idx, last_out, valid_out
    );

    // Producer/consumer side (MAC stage plus writeback).
    modport master (
        output D, shift, valid_in, ready_out,
        input  ready_in, row_out, row_idx, last_out, valid_out
    );

endinterface : mma_result_serializer_if

// File: rtl/mma_result_serializer_requant.sv
// Per-element requantizer: rounded arithmetic right shift, then saturation to OUT_W bits.
module requant_saturate
    import mma_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [ACC_W-1:0]   x,
    input  logic [SHIFT_W-1:0] shift,
    output logic [OUT_W-1:0]   y
);
    localparam logic [ACC_W:0]        ONE_X = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] MAX_S = $signed(ONE_X << (OUT_W - 1)) - $signed(ONE_X);
    localparam logic signed [ACC_W:0] MIN_S = -$signed(ONE_X << (OUT_W - 1));

    logic signed [ACC_W:0] ext_s;
    logic signed [ACC_W:0] bias_s;
    logic signed [ACC_W:0] sum_s;
    logic signed [ACC_W:0] shr_s;

    // One extra bit keeps x + 2^(s-1) from wrapping at the positive extreme.
    always_comb begin
        ext_s  = $signed({x[ACC_W-1], x});
        bias_s = '0;
        if (shift == '0) begin
            bias_s = '0;
        end else begin
            bias_s = $signed(ONE_X << (shift - SHIFT_W'(1)));
        end
        sum_s = ext_s + bias_s;
        shr_s = sum_s >>> shift;
        if (shr_s > MAX_S) begin
            y = MAX_S[OUT_W-1:0];
        end else if (shr_s < MIN_S) begin
            y = MIN_S[OUT_W-1:0];
        end else begin
            y = shr_s[OUT_W-1:0];
        end
    end

endmodule : requant_saturate

// File: rtl/mma_result_serializer.sv
// Buffers one D[M][N] matrix and streams it out one requantized row per beat.
module mma_result_serializer
    import mma_pkg::*;
#(
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int OUT_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    mma_result_serializer_if.slave  bus
);
    localparam int                RIDX_W       = (M > 1) ? $clog2(M) : 1;
    localparam logic [RIDX_W-1:0] LAST_IDX     = RIDX_W'(M - 1);
    localparam logic              LAST_ON_LOAD = 1'(M == 1);

    ser_state_e                     state_r;
    logic [M-1:0][N-1:0][ACC_W-1:0] buf_r;
    logic [SHIFT_W-1:0]             shift_r;
    logic [RIDX_W-1:0]              row_idx_r;
    logic                           last_r;
    logic                           valid_r;
    logic                           ready_in_s;
    logic                           accept_s;
    logic [N-1:0][ACC_W-1:0]        row_sel_s;

    // Accept while idle, or when the final row is leaving so the next matrix follows with no bubble.
    always_comb begin
        ready_in_s = 1'b0;
        if (state_r == IDLE) begin
            ready_in_s = 1'b1;
        end else if ((state_r == SEND) && last_r && bus.ready_out) begin
            ready_in_s = 1'b1;
        end else begin
            ready_in_s = 1'b0;
        end
        accept_s = bus.valid_in & ready_in_s;
    end

    // Serializer FSM: capture on acceptance, advance one row per completed beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            buf_r     <= '0;
            shift_r   <= '0;
            row_idx_r <= '0;
            last_r    <= 1'b0;
            valid_r   <= 1'b0;
        end else if (accept_s) begin
            state_r   <= SEND;
            buf_r     <= bus.D;
            shift_r   <= bus.shift;
            row_idx_r <= '0;
            last_r    <= LAST_ON_LOAD;
            valid_r   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                end
                SEND: begin
                    if (bus.ready_out) begin
                        if (last_r) begin
                            state_r   <= IDLE;
                            row_idx_r <= '0;
                            last_r    <= 1'b0;
                            valid_r   <= 1'b0;
                        end else begin
                            row_idx_r <= row_idx_r + RIDX_W'(1);
                            last_r    <= ((row_idx_r + RIDX_W'(1)) == LAST_IDX);
                        end
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    row_idx_r <= '0;
                    last_r    <= 1'b0;
                    valid_r   <= 1'b0;
                end
            endcase
        end
    end

    // Row mux ahead of requant, so only one row of requantizers is needed.
    always_comb begin
        row_sel_s = buf_r[row_idx_r];
    end

    for (genvar j = 0; j < N; j++) begin : g_rq
        requant_saturate #(.OUT_W(OUT_W)) u_rq (
            .x     (row_sel_s[j]),
            .shift (shift_r),
            .y     (bus.row_out[j])
        );
    end

    assign bus.ready_in  = ready_in_s;
    assign bus.row_idx   = row_idx_r;
    assign bus.last_out  = last_r;
    assign bus.valid_out = valid_r;

endmodule : mma_result_serializer

// File: tb/tb_mma_result_serializer.sv
// Bench for mma_result_serializer: directed identity/rounding/backpressure/back-to-back/reset plus random stress.
module tb_mma_result_serializer;
    import mma_pkg::*;

    localparam int BM = 4;
    localparam int BN = 4;
    localparam int BW = 8;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    mma_result_serializer_if #(.M(2),  .N(2),  .OUT_W(32)) ia ();
    mma_result_serializer_if #(.M(BM), .N(BN), .OUT_W(BW)) ib ();

    mma_result_serializer #(.M(2), .N(2), .OUT_W(32)) dut_a (
        .clk_i (clk), .rst_ni (rst_ni), .bus (ia)
    );
    mma_result_serializer #(.M(BM), .N(BN), .OUT_W(BW)) dut_b (
        .clk_i (clk), .rst_ni (rst_ni), .bus (ib)
    );

    typedef struct {
        logic [BN*BW-1:0] row;
        int               idx;
    } beat_t;

    beat_t            exp_q[$];
    logic [BN*BW-1:0] snap_row;
    logic [1:0]       snap_idx;
    logic             snap_last;
    bit               prev_stall = 1'b0;
    int               beats      = 0;
    int               accepts    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requant computed as rounded division by 2^s then clamped to the signed OUT_W range.
    function automatic longint ref_rq(input logic [31:0] x, input int s, input int ow);
        longint y, hi, lo;
        int     se;
        se = (s > 31) ? 31 : s;
        y  = longint'($signed(x));
        if (se > 0) y = (y + (longint'(1) <<< (se - 1))) >>> se;
        hi = (longint'(1) <<< (ow - 1)) - 1;
        lo = -(longint'(1) <<< (ow - 1));
        if (y > hi) y = hi;
        else if (y < lo) y = lo;
        return y;
    endfunction

    function automatic logic [31:0] rand_elem();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 255)) - 32'd128;
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic rand_matrix();
        for (int r = 0; r < BM; r++)
            for (int j = 0; j < BN; j++)
                ib.D[r][j] = rand_elem();
    endtask

    // One clock of dut_b: scoreboard checks at the falling edge, new inputs after the rising edge.
    task automatic cycle();
        beat_t e;
        @(negedge clk);
        if (prev_stall) begin
            chk("hold_valid", 64'(ib.valid_out), 64'(1));
            chk("hold_row",   64'(ib.row_out),   64'(snap_row));
            chk("hold_idx",   64'(ib.row_idx),   64'(snap_idx));
            chk("hold_last",  64'(ib.last_out),  64'(snap_last));
        end
        chk("valid_out", 64'(ib.valid_out), 64'(exp_q.size() != 0));
        chk("ready_in",  64'(ib.ready_in),
            64'((exp_q.size() == 0) || (exp_q.size() == 1 && ib.ready_out)));
        if (ib.valid_out && ib.ready_out && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("row",  64'(ib.row_out),  64'(e.row));
            chk("idx",  64'(ib.row_idx),  64'(e.idx));
            chk("last", 64'(ib.last_out), 64'(e.idx == BM - 1));
            beats++;
        end
        if (ib.valid_in && ib.ready_in) begin
            accepts++;
            for (int r = 0; r < BM; r++) begin
                e.idx = r;
                for (int j = 0; j < BN; j++)
                    e.row[j*BW +: BW] = BW'(ref_rq(ib.D[r][j], int'(ib.shift), BW));
                exp_q.push_back(e);
            end
        end
        prev_stall = ib.valid_out && !ib.ready_out;
        snap_row   = ib.row_out;
        snap_idx   = ib.row_idx;
        snap_last  = ib.last_out;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        ib.valid_in  = 1'b0;
        ib.ready_out = 1'b1;
        while (exp_q.size() > 0 && n < 100) begin
            cycle();
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int n;
        int beats0;

        ia.D = '0; ia.shift = '0; ia.valid_in = 1'b0; ia.ready_out = 1'b0;
        ib.D = '0; ib.shift = '0; ib.valid_in = 1'b0; ib.ready_out = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", 64'(ib.valid_out), 64'(0));
        chk("rst_ready", 64'(ib.ready_in),  64'(1));
        chk("rst_idx",   64'(ib.row_idx),   64'(0));
        chk("rst_last",  64'(ib.last_out),  64'(0));
        chk("rst_row",   64'(ib.row_out),   64'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Identity on the 2x2, 32-bit instance
        ia.D[0][0] = 32'd1; ia.D[0][1] = 32'd2; ia.D[1][0] = 32'd3; ia.D[1][1] = 32'd4;
        ia.shift = 5'd0; ia.ready_out = 1'b1; ia.valid_in = 1'b1;
        @(posedge clk);
        #1;
        ia.valid_in = 1'b0;
        chk("id_row0",   64'(ia.row_out),   {32'd2, 32'd1});
        chk("id_idx0",   64'(ia.row_idx),   64'(0));
        chk("id_last0",  64'(ia.last_out),  64'(0));
        chk("id_rdy0",   64'(ia.ready_in),  64'(0));
        @(posedge clk);
        #1;
        chk("id_row1",   64'(ia.row_out),   {32'd4, 32'd3});
        chk("id_idx1",   64'(ia.row_idx),   64'(1));
        chk("id_last1",  64'(ia.last_out),  64'(1));
        chk("id_rdy1",   64'(ia.ready_in),  64'(1));
        @(posedge clk);
        #1;
        chk("id_done_v", 64'(ia.valid_out), 64'(0));
        chk("id_done_r", 64'(ia.ready_in),  64'(1));

        // Rounding and saturation, followed by backpressure on row 1
        ib.D = '0;
        ib.D[0][0] = 32'd24;  ib.D[0][1] = -32'sd24; ib.D[0][2] = 32'd8;    ib.D[0][3] = 32'h7FFF_FFFF;
        ib.D[1][0] = 32'h8000_0000; ib.D[1][1] = 32'd2047; ib.D[1][2] = -32'sd40; ib.D[1][3] = 32'd7;
        ib.shift = 5'd4; ib.valid_in = 1'b1; ib.ready_out = 1'b0;
        cycle();
        ib.valid_in = 1'b0;
        chk("rq_row0", 64'(ib.row_out), 64'(32'h7F01_FF02));
        ib.ready_out = 1'b1;
        cycle();
        chk("rq_row1", 64'(ib.row_out), 64'(32'h00FE_7F80));
        ib.ready_out = 1'b0;
        repeat (5) cycle();
        chk("bp_idx", 64'(ib.row_idx), 64'(1));
        drain();

        // Back-to-back: three matrices with valid_in and ready_out held high
        ib.ready_out = 1'b1; ib.valid_in = 1'b1;
        accepts = 0; beats0 = beats; n = 0;
        while ((accepts < 3 || exp_q.size() > 0) && n < 60) begin
            rand_matrix();
            ib.shift = 5'($urandom_range(0, 31));
            cycle();
            n++;
            if (accepts >= 3) ib.valid_in = 1'b0;
        end
        chk("b2b_beats",  64'(beats - beats0), 64'(12));
        chk("b2b_cycles", 64'(n),              64'(13));

        // Asynchronous reset while row 2 is presented
        rand_matrix();
        ib.shift = 5'd3; ib.valid_in = 1'b1; ib.ready_out = 1'b1;
        cycle();
        ib.valid_in = 1'b0;
        cycle();
        cycle();
        chk("pre_rst_idx", 64'(ib.row_idx), 64'(2));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(ib.valid_out), 64'(0));
        chk("arst_ready", 64'(ib.ready_in),  64'(1));
        chk("arst_idx",   64'(ib.row_idx),   64'(0));
        chk("arst_last",  64'(ib.last_out),  64'(0));
        chk("arst_row",   64'(ib.row_out),   64'(0));
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        rand_matrix();
        ib.valid_in = 1'b1;
        cycle();
        ib.valid_in = 1'b0;
        chk("restart_idx", 64'(ib.row_idx), 64'(0));
        drain();

        // Random stress
        repeat (400) begin
            ib.valid_in  = 1'($urandom_range(0, 1));
            ib.ready_out = ($urandom_range(0, 3) != 0);
            ib.shift     = 5'($urandom_range(0, 31));
            rand_matrix();
            cycle();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mma_result_serializer
